// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered 8N1 UART transmitter. Bytes written by any byte source are queued
// in a small FIFO and sent back-to-back on the serial pin, LSB first.
//
// Ports:
//   i_clk       system clock, all state updates on the rising edge
//   i_reset     synchronous active-high reset
//   i_data_in   byte to enqueue
//   i_wr_en     enqueue request, sampled every cycle
//   o_full      FIFO holds FIFO_DEPTH entries
//   o_count     current FIFO occupancy
//   o_overflow  one-cycle pulse when a write is dropped because the FIFO is full
//   o_busy      a frame is on the line (START, DATA or STOP)
//   o_tx        registered serial output, idles high
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [7:0]                    i_data_in,
  input  logic                          i_wr_en,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic                          o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Transmitter state
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Next-state values from the FSM combinational process
  state_t        w_nextState;
  logic [BW-1:0] w_nextBaud;
  logic [2:0]    w_nextBitIdx;
  logic [7:0]    w_nextShift;
  logic          w_nextTx;
  logic          w_pop;

  logic          w_full;
  logic          w_wrAccept;
  logic          w_baudDone;
  logic          w_notEmpty;

  // Full is judged on the pre-edge count, so a write on a full FIFO is dropped
  // even when the transmitter pops on that same edge.
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_notEmpty = (r_count != '0);
  assign w_wrAccept = i_wr_en & ~w_full;
  assign w_baudDone = (r_baud == '0);

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr] <= i_data_in;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_wr_en & w_full;
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_wrAccept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register; reset abandons any frame and forces the line high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_baud   <= w_nextBaud;
      r_bitIdx <= w_nextBitIdx;
      r_shift  <= w_nextShift;
      r_tx     <= w_nextTx;
    end
  end

  // FSM next-state logic. The baud counter reloads on every bit transition and
  // the bit ends when it reaches zero. The shift register moves right once per
  // data bit so the next bit to send is always at index 1 (index 0 is on the line).
  always_comb begin
    w_nextState  = r_state;
    w_nextBaud   = r_baud;
    w_nextBitIdx = r_bitIdx;
    w_nextShift  = r_shift;
    w_nextTx     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextTx = 1'b1;
        if (w_notEmpty) begin
          w_pop       = 1'b1;
          w_nextShift = r_mem[r_rdPtr];
          w_nextTx    = 1'b0;
          w_nextBaud  = BAUD_RELOAD;
          w_nextState = START;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_nextState  = DATA;
          w_nextBitIdx = 3'd0;
          w_nextTx     = r_shift[0];
          w_nextBaud   = BAUD_RELOAD;
        end else begin
          w_nextBaud = r_baud - BW'(1);
        end
      end
      DATA: begin
        if (w_baudDone) begin
          w_nextBaud = BAUD_RELOAD;
          if (r_bitIdx == 3'd7) begin
            w_nextState = STOP;
            w_nextTx    = 1'b1;
          end else begin
            w_nextBitIdx = r_bitIdx + 3'd1;
            w_nextShift  = r_shift >> 1;
            w_nextTx     = r_shift[1];
          end
        end else begin
          w_nextBaud = r_baud - BW'(1);
        end
      end
      STOP: begin
        if (w_baudDone) begin
          if (w_notEmpty) begin
            w_pop       = 1'b1;
            w_nextShift = r_mem[r_rdPtr];
            w_nextTx    = 1'b0;
            w_nextBaud  = BAUD_RELOAD;
            w_nextState = START;
          end else begin
            w_nextTx    = 1'b1;
            w_nextState = IDLE;
          end
        end else begin
          w_nextBaud = r_baud - BW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextTx    = 1'b1;
      end
    endcase
  end

  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_state != IDLE);
  assign o_tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Scoreboard bench for uart_tx_fifo. A fast instance (4 clocks per bit, depth 4)
// carries the functional scenarios; a default-parameter instance checks the
// real baud timing of the start bit.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dataIn;
  logic       wrEn;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       busy;
  logic       tx;

  logic       reset2;
  logic [7:0] dataIn2;
  logic       wrEn2;
  logic       full2;
  logic [4:0] count2;
  logic       overflow2;
  logic       busy2;
  logic       tx2;

  int total = 0;
  int bad   = 0;

  // Scoreboard of bytes that must appear on tx, in order
  logic [7:0] expQ [$];

  // Monitor state and per-test statistics
  logic inFrame = 1'b0;
  int   sampleIdx = 0;
  logic frameBuf [FRAME];
  logic busyBad = 1'b0;
  int   idleRun = 0;
  int   gapSum = 0;
  int   framesSeen = 0;
  int   busyCycles = 0;
  int   maxCount = 0;
  int   ovfPulses = 0;
  int   txLowCycles = 0;
  logic levelBad;
  logic [7:0] decoded;
  logic [7:0] expByte;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_data_in(dataIn), .i_wr_en(wrEn),
    .o_full(full), .o_count(count), .o_overflow(overflow),
    .o_busy(busy), .o_tx(tx)
  );

  uart_tx_fifo dutDefault (
    .i_clk(clk), .i_reset(reset2), .i_data_in(dataIn2), .i_wr_en(wrEn2),
    .o_full(full2), .o_count(count2), .o_overflow(overflow2),
    .o_busy(busy2), .o_tx(tx2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one write so that it is sampled on the next rising edge
  task automatic applyStimulus(input logic [7:0] b, input bit sent);
    dataIn = b;
    wrEn   = 1'b1;
    if (sent) expQ.push_back(b);
    @(posedge clk);
    #1;
    wrEn = 1'b0;
  endtask

  task automatic clearStats();
    busyCycles  = 0;
    maxCount    = 0;
    ovfPulses   = 0;
    txLowCycles = 0;
    gapSum      = 0;
    framesSeen  = 0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || count != 0 || inFrame) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleReached", (n < limit), 1);
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  // Monitor: captures each frame cycle by cycle on the falling edge, checks
  // every bit level is held for exactly C cycles, then pops the scoreboard.
  always @(negedge clk) begin
    if (busy) busyCycles++;
    if (int'(count) > maxCount) maxCount = int'(count);
    if (overflow) ovfPulses++;
    if (tx === 1'b0) txLowCycles++;
    if (reset) begin
      inFrame   = 1'b0;
      sampleIdx = 0;
      idleRun   = 0;
    end else begin
      if (!inFrame && tx === 1'b0) begin
        inFrame   = 1'b1;
        sampleIdx = 0;
        busyBad   = 1'b0;
        if (framesSeen > 0) gapSum += idleRun;
        idleRun = 0;
        framesSeen++;
      end
      if (inFrame) begin
        frameBuf[sampleIdx] = tx;
        if (busy !== 1'b1) busyBad = 1'b1;
        sampleIdx++;
        if (sampleIdx == FRAME) begin
          inFrame  = 1'b0;
          levelBad = 1'b0;
          for (int b = 0; b < 10; b++)
            for (int k = 0; k < C; k++)
              if (frameBuf[b*C+k] !== frameBuf[b*C]) levelBad = 1'b1;
          for (int i = 0; i < 8; i++) decoded[i] = frameBuf[(i+1)*C];
          checkOutput("frameShape",
                      {levelBad, busyBad, frameBuf[0], frameBuf[9*C]}, 4'b0001);
          if (expQ.size() == 0) begin
            checkOutput("frameExpected", 0, 1);
          end else begin
            expByte = expQ.pop_front();
            checkOutput("frameByte", decoded, expByte);
          end
        end
      end else begin
        idleRun++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitN;
    int lowLen;
    reset = 1'b1; wrEn = 1'b0; dataIn = 8'h00;
    reset2 = 1'b1; wrEn2 = 1'b0; dataIn2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState", {tx, busy, full, count, overflow}, {1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0; reset2 = 1'b0;

    // Single byte 0x55
    $display("[TB] single byte");
    clearStats();
    applyStimulus(8'h55, 1);
    @(negedge clk);
    checkOutput("afterWrite", {tx, busy, count}, {1'b1, 1'b0, 3'd1});
    @(negedge clk);
    checkOutput("afterPop", {tx, busy, count}, {1'b0, 1'b1, 3'd0});
    waitIdle(200);
    checkOutput("singleBusy", busyCycles, 40);

    // Back-to-back frames
    $display("[TB] back-to-back");
    clearStats();
    applyStimulus(8'h41, 1);
    applyStimulus(8'h42, 1);
    applyStimulus(8'h43, 1);
    waitIdle(500);
    checkOutput("b2bPeak", maxCount, 2);
    checkOutput("b2bGap", gapSum, 0);
    checkOutput("b2bFrames", framesSeen, 3);
    checkOutput("b2bBusy", busyCycles, 120);

    // Overflow with depth 4: five accepted, sixth dropped
    $display("[TB] overflow");
    clearStats();
    applyStimulus(8'h10, 1);
    applyStimulus(8'h11, 1);
    applyStimulus(8'h12, 1);
    applyStimulus(8'h13, 1);
    applyStimulus(8'h14, 1);
    @(negedge clk);
    checkOutput("fullAfterFifth", {full, count, overflow}, {1'b1, 3'd4, 1'b0});
    #1;
    applyStimulus(8'h15, 0);
    @(negedge clk);
    checkOutput("overflowPulse", {overflow, full, count}, {1'b1, 1'b1, 3'd4});
    @(negedge clk);
    checkOutput("overflowClear", overflow, 0);
    waitIdle(1000);
    checkOutput("overflowCount", ovfPulses, 1);

    // Simultaneous write and pop at the stop-bit end edge
    $display("[TB] simultaneous write and pop");
    clearStats();
    applyStimulus(8'h3C, 1);
    applyStimulus(8'hC3, 1);
    repeat (39) @(posedge clk);
    #1;
    applyStimulus(8'h7E, 1);
    @(negedge clk);
    checkOutput("simulCount", {count, tx, busy}, {3'd1, 1'b0, 1'b1});
    waitIdle(500);
    checkOutput("simulGap", gapSum, 0);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h66, 1);
    applyStimulus(8'h99, 1);
    checkOutput("queuedBeforeReset", count, 2);
    repeat (16) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("afterReset", {tx, busy, count}, {1'b1, 1'b0, 3'd0});
    clearStats();
    repeat (60) @(negedge clk);
    checkOutput("quietTxLow", txLowCycles, 0);
    checkOutput("quietBusy", busyCycles, 0);
    #1;
    applyStimulus(8'h5A, 1);
    waitIdle(200);

    // Default baud: start bit length on the full-size instance
    $display("[TB] default baud");
    dataIn2 = 8'h0D;
    wrEn2   = 1'b1;
    @(posedge clk);
    #1;
    wrEn2 = 1'b0;
    waitN = 0;
    @(negedge clk);
    while (tx2 !== 1'b0 && waitN < 10) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("defaultStartSeen", tx2, 0);
    lowLen = 0;
    while (tx2 === 1'b0 && lowLen < 20000) begin
      lowLen++;
      @(negedge clk);
    end
    checkOutput("defaultStartLen", lowLen, 10416);
    checkOutput("defaultBit0", {tx2, busy2}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the terminal-display system. It is the transmit-direction counterpart to the received-character path that feeds the VGA and seven-segment display. Bytes from the switch/button logic, or any future byte source, are queued in a small FIFO. They are then serialised on the TX pin as 8N1 frames, with back-to-back frames whenever more data is queued.

## Interface

- CLKS_PER_BIT, default 10416: clk cycles per UART bit. 100 MHz / 9600 baud, truncated. Must be ≥ 2.
- FIFO_DEPTH, default 16: FIFO entries. Must be a power of two, ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to enqueue.
- wr_en  in  1  enqueue request; sampled every cycle.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- busy  out  1  a frame is on the line (START, DATA or STOP state).
- tx  out  1  serial output, registered; idle level is 1.

## Operation

- **Reset.** When reset=1 at an edge:
  - tx=1, busy=0, full=0, count=0, overflow=0.
  - FSM returns to IDLE; FIFO pointers clear.
  - A frame in progress is abandoned immediately, with tx forced to 1 on that edge.
- **Write.**
  - wr_en=1 and full=0: data_in is stored at the write pointer.
  - wr_en=1 and full=1: the byte is discarded and overflow=1 for the next cycle. This holds even if a pop occurs on the same edge, because full is evaluated from the pre-edge count.
  - wr_en=0: nothing happens.
- **Count.** +1 on write only, −1 on pop only, unchanged on a simultaneous write and pop. full = (count == FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- **FSM states:**
  - **IDLE:** tx=1, busy=0. If count>0, pop the head byte into the shift register, set tx=0 and go to START.
  - **START:** hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - **DATA:** send shift-register bits LSB first, each for CLKS_PER_BIT cycles. After bit 7, go to STOP with tx=1.
  - **STOP:** hold tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit, if count>0, pop and go straight to START (tx=0 on that same edge). Otherwise go to IDLE.
- **Baud timing.** A single down-counter reloads CLKS_PER_BIT−1 at every bit transition; the bit ends when the counter reaches 0.
- **Write during IDLE with an empty FIFO.** The write is visible as count=1 in the following cycle. The FSM pops on the next edge.

## Timing

- **Latency.** If wr_en is accepted at edge E0 with the FSM in IDLE, count=1 after E0. At E1 the pop occurs: count=0 and tx=0, busy=1.
- **Frame length.** Exactly 10×CLKS_PER_BIT cycles, measured from the tx falling edge to the end of the stop bit.
- **Back-to-back frames.** Consecutive queued bytes produce no idle cycles between the stop bit and the next start bit.
- **busy.** Rises on the same edge tx first goes low. It falls on the edge the FSM enters IDLE.
- **overflow.** A single-cycle pulse for each dropped write. A sustained wr_en while full produces one pulse per dropped cycle.
- **tx.** Registered output, glitch-free; it changes only on bit boundaries or reset.

## Test plan

- **Single byte.** Use CLKS_PER_BIT=4. Write 0x55 once from idle.
  - tx must be 1 for the cycle after the write.
  - Then tx must show 0 (start), 1,0,1,0,1,0,1,0 (data), 1 (stop), each level exactly 4 cycles.
  - busy must be high for exactly 40 cycles; count must return to 0.
- **Back-to-back frames.** Write 0x41, 0x42, 0x43 on consecutive cycles.
  - count must peak at 2.
  - Three frames must appear on tx with no idle cycle between the stop and start bits.
  - Decoded bytes must be 0x41, 0x42, 0x43; total busy time must be 120 cycles.
- **Overflow.** Use FIFO_DEPTH=4. Hold the FSM mid-frame and write 6 bytes on consecutive cycles.
  - One byte is popped at the start, leaving the first 4 subsequent writes queued; full=1 after the 5th accepted write.
  - The 6th write must pulse overflow for 1 cycle.
  - Transmitted order must match accepted order exactly.
- **Simultaneous write and pop.** Keep count=1 and time a write onto the stop-bit end edge. count must stay at 1 and both bytes must be transmitted in order.
- **Reset mid-frame.** Assert reset during data bit 3 of 0xA5 with 2 bytes queued.
  - The next edge must show tx=1, busy=0, count=0.
  - No further frames may occur until a new write.
- **Default baud.** Use CLKS_PER_BIT=10416. Write 0x0D. The start bit must last exactly 10416 cycles and the whole frame 104160 cycles.
